sev_seg_driver: RTL and testbench
=================================

// Module: sev_seg_driver
// PURPOSE
//   Time-multiplexed driver for a 4-digit common-anode 7-segment display.
//   Takes four 4-bit hex nibbles, scans one digit at a time, and drives
//   active-low digit enables plus active-low segment lines. Sits between
//   the combo-lock core (value/status nibbles) and the board display pins.
// PARAMETERS
//   DIGIT_CYCLES  4  clk cycles each digit stays lit (>=1); board top overrides (e.g. 100000)
// PORTS
//   clk    in   1  single system clock, rising edge
//   rst    in   1  synchronous, active-high reset
//   disp3  in   4  hex value, leftmost digit (segEn[3])
//   disp2  in   4  hex value, digit 2
//   disp1  in   4  hex value, digit 1
//   disp0  in   4  hex value, rightmost digit (segEn[0])
//   segEn  out  4  digit enables, active-low, one-cold
//   seg    out  7  segments {g,f,e,d,c,b,a}, active-low
// BEHAVIOUR
//   - One clock (clk); reset is synchronous and active-high (rst).
//   - Internal: tick counter 0..DIGIT_CYCLES-1 ($clog2 width, min 1 bit);
//     2-bit digit select sel. Tick wraps to 0 -> sel increments 0,1,2,3,0.
//   - rst=1 at an edge: tick=0, sel=0, segEn=4'b1111, seg=7'h7F (all dark).
//     Applies at any time, including mid-scan.
//   - Outputs registered. On each non-reset edge, register state for the
//     current sel: segEn = ~(4'b0001 << sel), seg = decode(disp[sel]).
//     First edge after rst falls lights digit 0.
//   - Inputs sampled every edge (no per-scan latch); change on active digit
//     appears on seg one edge later.
//   - Each digit is lit exactly DIGIT_CYCLES edges; full frame 4*DIGIT_CYCLES.
//     DIGIT_CYCLES=1: digit advances every edge.
//   - Decode (hex->seg, active-low):
//     0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78
//     8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E
//   - No X-propagation: unknown sel never occurs (full case, default dark).
// CONFIGURATION
//   SEVSEG_LZ_BLANK_EN defined: leading-zero blanking. Digit3 dark if
//     disp3==0; digit2 dark if disp3==disp2==0; digit1 dark if
//     disp3..disp1 all 0; digit0 never blanked. Dark digit: segEn bit=1,
//     seg=7'h7F for its scan slot; scan timing unchanged.
//   Undefined (default): all four digits always displayed, zeros included.
// TESTING  (DIGIT_CYCLES=4)
//   - rst=1 for 2 edges -> segEn=1111, seg=7F; release -> next edge
//     segEn=1110, seg=40 (disp*=0).
//   - disp=3,2,1,0 -> segEn 1110/1101/1011/0111 each 4 edges with
//     seg 40/79/24/30, repeating.
//   - disp0 0->1 while digit0 lit -> seg 40->79 one edge later.
//   - Sweep disp0 0..F -> seg matches decode table for each value.
//   - rst pulse while digit2 lit -> dark for that edge, then digit0 restarts.
//   - SEVSEG_LZ_BLANK_EN, disp=0,0,1,0 -> digits 3,2 dark (1111/7F), digit1 79, digit0 40.

Source files
------------

// File: rtl/sev_seg_driver.sv
// Scanned 4-digit common-anode 7-segment driver with registered outputs.
// Optional leading-zero blanking when SEVSEG_LZ_BLANK_EN is defined.
module sev_seg_driver #(
    parameter int DIGIT_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] disp3,
    input  logic [3:0] disp2,
    input  logic [3:0] disp1,
    input  logic [3:0] disp0,
    output logic [3:0] segEn,
    output logic [6:0] seg
);

    localparam int TW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(DIGIT_CYCLES - 1);

    logic [TW-1:0] tick;
    logic [1:0]    sel;
    logic [3:0]    cur;
    logic          blank;
    logic [3:0]    en_next;
    logic [6:0]    seg_next;

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        cur = 4'h0;
        case (sel)
            2'd0: cur = disp0;
            2'd1: cur = disp1;
            2'd2: cur = disp2;
            2'd3: cur = disp3;
            default: cur = 4'h0;
        endcase
    end

    always_comb begin
        blank = 1'b0;
`ifdef SEVSEG_LZ_BLANK_EN
        // A digit is blank when it and every digit to its left are zero.
        case (sel)
            2'd3: blank = (disp3 == 4'h0);
            2'd2: blank = (disp3 == 4'h0) && (disp2 == 4'h0);
            2'd1: blank = (disp3 == 4'h0) && (disp2 == 4'h0)
                          && (disp1 == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
        if (blank) begin
            en_next  = 4'b1111;
            seg_next = 7'h7F;
        end else begin
            en_next  = ~(4'b0001 << sel);
            seg_next = decode(cur);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick  <= '0;
            sel   <= 2'd0;
            segEn <= 4'b1111;
            seg   <= 7'h7F;
        end else begin
            segEn <= en_next;
            seg   <= seg_next;
            if (tick == TICK_MAX) begin
                tick <= '0;
                sel  <= sel + 2'd1;
            end else begin
                tick <= tick + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sev_seg_driver.sv
// Randomised bench for sev_seg_driver against an edge-count display model.
// Honors SEVSEG_LZ_BLANK_EN for both model and literal checks.
module tb_sev_seg_driver;

    localparam int DC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] disp3 = 4'h0;
    logic [3:0] disp2 = 4'h0;
    logic [3:0] disp1 = 4'h0;
    logic [3:0] disp0 = 4'h0;
    logic [3:0] segEn;
    logic [6:0] seg;

    int total = 0;
    int bad = 0;

    sev_seg_driver #(.DIGIT_CYCLES(DC)) dut (
        .clk(clk), .rst(rst),
        .disp3(disp3), .disp2(disp2), .disp1(disp1), .disp0(disp0),
        .segEn(segEn), .seg(seg)
    );

    always #5 clk = ~clk;

    logic [6:0] table7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30,
                                7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03,
                                7'h46, 7'h21, 7'h06, 7'h0E};

    // Model: edges since reset release decide which digit is lit.
    int         n = 0;
    bit         valid = 0;
    logic [3:0] exp_en;
    logic [6:0] exp_seg;

    always @(posedge clk) begin
        logic [3:0] v [4];
        int d;
        bit dark;
        v[0] = disp0; v[1] = disp1; v[2] = disp2; v[3] = disp3;
        if (rst) begin
            n = 0;
            valid = 1;
            exp_en = 4'b1111;
            exp_seg = 7'h7F;
        end else begin
            d = (n / DC) % 4;
            dark = 0;
`ifdef SEVSEG_LZ_BLANK_EN
            if (d > 0) begin
                dark = 1;
                for (int k = d; k <= 3; k++)
                    if (v[k] != 4'h0) dark = 0;
            end
`endif
            if (dark) begin
                exp_en = 4'b1111;
                exp_seg = 7'h7F;
            end else begin
                exp_en = 4'b1111;
                exp_en[d] = 1'b0;
                exp_seg = table7[v[d]];
            end
            n++;
        end
    end

    always @(negedge clk) begin
        if (valid) begin
            total++;
            if (segEn !== exp_en) begin
                bad++;
                $display("FAIL model_segEn t=%0t got=%b want=%b",
                         $time, segEn, exp_en);
            end
            total++;
            if (seg !== exp_seg) begin
                bad++;
                $display("FAIL model_seg t=%0t got=%h want=%h",
                         $time, seg, exp_seg);
            end
        end
    end

    task automatic lit(input string nm, input logic [3:0] en,
                       input logic [6:0] sg);
        total++;
        if (segEn !== en || seg !== sg) begin
            bad++;
            $display("FAIL %s got=%b/%h want=%b/%h", nm, segEn, seg, en, sg);
        end
    endtask

    task automatic set_disp(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
        disp3 = a; disp2 = b; disp1 = c; disp0 = d;
    endtask

    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [6:0] seq_seg [4] = '{7'h40, 7'h79, 7'h24, 7'h30};
    logic [3:0] seq_en  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        @(negedge clk);
        @(negedge clk);
        lit("reset_dark", 4'b1111, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        lit("first_digit0", 4'b1110, 7'h40);

        set_disp(4'h3, 4'h2, 4'h1, 4'h0);
        restart();
        for (int k = 0; k < 2 * 4 * DC; k++) begin
            @(negedge clk);
            lit("scan_seq", seq_en[(k / DC) % 4], seq_seg[(k / DC) % 4]);
        end

        restart();
        @(negedge clk);
        lit("d0_before", 4'b1110, 7'h40);
        disp0 = 4'h1;
        @(negedge clk);
        lit("d0_after", 4'b1110, 7'h79);

        for (int v = 0; v < 16; v++) begin
            disp0 = 4'(v);
            restart();
            @(negedge clk);
        end

        set_disp(4'h3, 4'h2, 4'h1, 4'h0);
        restart();
        repeat (2 * DC + 1) @(negedge clk);
        lit("mid_digit2", 4'b1011, 7'h24);
        rst = 1'b1;
        @(negedge clk);
        lit("mid_reset", 4'b1111, 7'h7F);
        rst = 1'b0;
        @(negedge clk);
        lit("restart_d0", 4'b1110, 7'h40);

`ifdef SEVSEG_LZ_BLANK_EN
        set_disp(4'h0, 4'h0, 4'h1, 4'h0);
        restart();
        repeat (DC) @(negedge clk);
        lit("lz_d0", 4'b1110, 7'h40);
        repeat (DC) @(negedge clk);
        lit("lz_d1", 4'b1101, 7'h79);
        repeat (DC) @(negedge clk);
        lit("lz_d2", 4'b1111, 7'h7F);
        repeat (DC) @(negedge clk);
        lit("lz_d3", 4'b1111, 7'h7F);
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                if ($urandom_range(0, 1) == 0)
                    set_disp(4'h0, 4'h0, 4'($urandom_range(0, 1)),
                             4'($urandom));
                else
                    set_disp(4'($urandom), 4'($urandom),
                             4'($urandom), 4'($urandom));
            end
            rst = ($urandom_range(0, 99) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
